gpp_top: RTL and testbench

// Top of a 32-bit multicycle MIPS-subset general-purpose processor with a unified word SRAM.
// A host preloads the program and data through a simple SRAM port while the core idles.
// The host pulses Str, the core runs until it fetches HALT, then raises Done.
// The host can then read results back through the same port.

---
 rtl/gpp_top.sv | 159 +++++++++++++++
 tb/tb_gpp_top.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpp_top.sv
// Multicycle 32-bit MIPS-subset processor with a unified word SRAM.
// The host loads and reads the SRAM while the core is idle (S_WAIT/S_DONE).
module gpp_top #(
    parameter int unsigned D_WIDTH  = 32,
    parameter int unsigned SA_WIDTH = 5,
    parameter int unsigned SL_WIDTH = 32
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Rst_M,
    input  logic                Str,
    output logic                Done,
    input  logic [SA_WIDTH-1:0] Addr,
    input  logic [D_WIDTH-1:0]  Data_I,
    output logic [D_WIDTH-1:0]  Data_O,
    input  logic                En,
    input  logic                RW
);

    localparam logic [2:0] S_WAIT   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_MEM    = 3'd5;
    localparam logic [2:0] S_WB     = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;

    logic [2:0]         state_q, state_d;
    logic [D_WIDTH-1:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q, data_o_q;
    logic [D_WIDTH-1:0] rf_q [32];
    logic [D_WIDTH-1:0] mem_q [SL_WIDTH];

    logic [5:0]         op, funct;
    logic [4:0]         rs, rt, rd;
    logic [D_WIDTH-1:0] imm_sext, alu_res, wb_data;
    logic               host_ok, is_mem, wb_en;
    logic [4:0]         wb_rd;
    logic [SA_WIDTH-1:0] pc_idx, ea_idx;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign host_ok  = (state_q == S_WAIT) || (state_q == S_DONE);
    assign is_mem   = (op == OP_LW) || (op == OP_SW);
    assign pc_idx   = pc_q[SA_WIDTH+1:2];
    assign ea_idx   = alu_q[SA_WIDTH+1:2];
    assign Done     = (state_q == S_DONE);
    assign Data_O   = data_o_q;

    // Address bits above the SRAM index wrap; shamt is not part of this subset.
    logic unused_bits;
    assign unused_bits = ^{alu_q[D_WIDTH-1:SA_WIDTH+2], alu_q[1:0], pc_q[1:0], ir_q[10:6]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_WAIT:   if (Str) state_d = S_INIT;
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = (op == OP_HALT) ? S_DONE : S_EXEC;
            S_EXEC:   state_d = is_mem ? S_MEM : S_WB;
            S_MEM:    state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_DONE:   if (Str) state_d = S_INIT;
            default:  state_d = S_WAIT;
        endcase
    end

    always_comb begin
        alu_res = a_q + imm_sext;
        if (op == OP_R) begin
            case (funct)
                6'h20:   alu_res = a_q + b_q;
                6'h22:   alu_res = a_q - b_q;
                6'h24:   alu_res = a_q & b_q;
                6'h25:   alu_res = a_q | b_q;
                6'h2A:   alu_res = {{(D_WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
                default: alu_res = '0;
            endcase
        end
    end

    always_comb begin
        wb_en   = 1'b0;
        wb_rd   = rt;
        wb_data = alu_q;
        case (op)
            OP_R: begin
                wb_rd = rd;
                wb_en = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                        (funct == 6'h25) || (funct == 6'h2A);
            end
            OP_ADDI: wb_en = 1'b1;
            OP_LW: begin
                wb_en   = 1'b1;
                wb_data = mdr_q;
            end
            default: wb_en = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= S_WAIT;
            pc_q     <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            data_o_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (host_ok && En && !RW) data_o_q <= mem_q[Addr];
            case (state_q)
                S_INIT:  pc_q <= '0;
                S_FETCH: ir_q <= mem_q[pc_idx];
                S_DECODE: begin
                    a_q <= rf_q[rs];
                    b_q <= rf_q[rt];
                    if (op != OP_HALT) pc_q <= pc_q + 32'd4;
                end
                S_EXEC: begin
                    alu_q <= alu_res;
                    if (op == OP_BEQ && a_q == b_q) pc_q <= pc_q + (imm_sext << 2);
                    if (op == OP_J) pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
                end
                S_MEM: if (op == OP_LW) mdr_q <= mem_q[ea_idx];
                S_WB:  if (wb_en && wb_rd != 5'd0) rf_q[wb_rd] <= wb_data;
                default: ;
            endcase
        end
    end

    // SRAM has no core reset; Rst still gates the sw write so an aborted store is dropped.
    always_ff @(posedge Clk) begin
        if (Rst_M) begin
            for (int i = 0; i < int'(SL_WIDTH); i++) mem_q[i] <= '0;
        end else if (host_ok && En && RW) begin
            mem_q[Addr] <= Data_I;
        end else if (Rst && state_q == S_MEM && op == OP_SW) begin
            mem_q[ea_idx] <= b_q;
        end
    end

endmodule

// File: tb/tb_gpp_top.sv
// Directed bench for gpp_top: host SRAM access, ISA programs checked against an
// instruction-level reference model, reset abort and restart behaviour.
module tb_gpp_top;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Rst_M = 1'b0;
    logic        Str = 1'b0;
    logic        Done;
    logic [4:0]  Addr = '0;
    logic [31:0] Data_I = '0;
    logic [31:0] Data_O;
    logic        En = 1'b0;
    logic        RW = 1'b0;

    gpp_top dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Rst_M  (Rst_M),
        .Str    (Str),
        .Done   (Done),
        .Addr   (Addr),
        .Data_I (Data_I),
        .Data_O (Data_O),
        .En     (En),
        .RW     (RW)
    );

    always #5 Clk = ~Clk;

    int ntests = 0;
    int nfail  = 0;

    logic [31:0] mem_m [32];
    logic [31:0] rm [32];
    logic [31:0] exp_do = '0;
    logic        exp_done = 1'b0;
    logic        chk_on = 1'b0;
    logic        chk_done = 1'b0;
    logic        idle_m = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_on) chk("data_o", Data_O, exp_do);
        if (chk_on && chk_done) chk("done", {31'b0, Done}, {31'b0, exp_done});
    end

    function automatic logic [31:0] i_addi(input int rt, input int rs, input int imm);
        logic [15:0] im;
        im = 16'(imm);
        return {6'h08, 5'(rs), 5'(rt), im};
    endfunction
    function automatic logic [31:0] i_r(input logic [5:0] fn, input int rd, input int rs,
                                        input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction
    function automatic logic [31:0] i_mem(input logic [5:0] op, input int rt, input int off);
        logic [15:0] im;
        im = 16'(off);
        return {op, 5'd0, 5'(rt), im};
    endfunction
    function automatic logic [31:0] i_beq(input int rs, input int rt, input int off);
        logic [15:0] im;
        im = 16'(off);
        return {6'h04, 5'(rs), 5'(rt), im};
    endfunction
    localparam logic [31:0] HALT = {6'h3F, 26'd0};

    // Instruction-level reference: run the program in mem_m from PC 0 to HALT.
    task automatic run_model();
        logic [31:0] pc, ir, a, b, imm, ea, v;
        logic [5:0] op;
        pc = 0;
        for (int steps = 0; steps < 1000; steps++) begin
            ir = mem_m[pc[6:2]];
            op = ir[31:26];
            if (op == 6'h3F) return;
            a = rm[ir[25:21]];
            b = rm[ir[20:16]];
            imm = {{16{ir[15]}}, ir[15:0]};
            ea = a + imm;
            pc = pc + 4;
            if (op == 6'h00) begin
                v = 'x;
                case (ir[5:0])
                    6'h20: v = a + b;
                    6'h22: v = a - b;
                    6'h24: v = a & b;
                    6'h25: v = a | b;
                    6'h2A: v = ($signed(a) < $signed(b)) ? 1 : 0;
                    default: ;
                endcase
                if (!$isunknown(v) && ir[15:11] != 0) rm[ir[15:11]] = v;
            end else if (op == 6'h08) begin
                if (ir[20:16] != 0) rm[ir[20:16]] = ea;
            end else if (op == 6'h23) begin
                if (ir[20:16] != 0) rm[ir[20:16]] = mem_m[ea[6:2]];
            end else if (op == 6'h2B) begin
                mem_m[ea[6:2]] = b;
            end else if (op == 6'h04) begin
                if (a == b) pc = pc + (imm << 2);
            end else if (op == 6'h02) begin
                pc = {pc[31:28], ir[25:0], 2'b00};
            end
        end
        chk("model_halt", 32'd0, 32'd1);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic core_reset();
        chk_done = 1'b0;
        Rst = 1'b0;
        #1;
        exp_do = '0;
        exp_done = 1'b0;
        idle_m = 1'b1;
        for (int i = 0; i < 32; i++) rm[i] = '0;
        chk("rst_done", {31'b0, Done}, 32'd0);
        chk("rst_data_o", Data_O, 32'd0);
        tick();
        Rst = 1'b1;
        chk_done = 1'b1;
    endtask

    task automatic host_write(input int a, input logic [31:0] d);
        En = 1'b1;
        RW = 1'b1;
        Addr = 5'(a);
        Data_I = d;
        tick();
        if (idle_m) mem_m[a] = d;
        En = 1'b0;
    endtask

    task automatic host_read(input int a);
        En = 1'b1;
        RW = 1'b0;
        Addr = 5'(a);
        tick();
        if (idle_m) exp_do = mem_m[a];
        En = 1'b0;
    endtask

    task automatic mem_clear();
        Rst_M = 1'b1;
        tick();
        Rst_M = 1'b0;
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
    endtask

    task automatic start_core();
        chk_done = 1'b0;
        Str = 1'b1;
        tick();
        Str = 1'b0;
        idle_m = 1'b0;
        chk("start_done_low", {31'b0, Done}, 32'd0);
    endtask

    task automatic wait_done(input string nm);
        for (int n = 0; n < 2000 && !Done; n++) tick();
        chk(nm, {31'b0, Done}, 32'd1);
        run_model();
        idle_m = 1'b1;
        exp_done = 1'b1;
        chk_done = 1'b1;
    endtask

    task automatic load_prog(input logic [31:0] p [], input int n);
        for (int i = 0; i < n; i++) host_write(i, p[i]);
    endtask

    logic [31:0] prog [];

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem_m[i] = '0;
            rm[i] = '0;
        end
        #2;
        core_reset();
        chk_on = 1'b1;
        mem_clear();

        // Host load/readback and SRAM clear
        host_write(0, 32'h11);
        host_write(1, 32'h22);
        host_write(2, 32'h33);
        host_write(3, 32'h44);
        host_read(2);
        chk("readback_lit", Data_O, 32'h33);
        Rst_M = 1'b1;
        En = 1'b1;
        RW = 1'b1;
        Addr = 5'd1;
        Data_I = 32'hBAD;
        tick();
        Rst_M = 1'b0;
        En = 1'b0;
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
        host_read(2);
        chk("clear_lit", Data_O, 32'h0);
        host_read(1);
        chk("clear_prio_lit", Data_O, 32'h0);

        // ALU program
        prog = new[9];
        prog[0] = i_addi(1, 0, 5);
        prog[1] = i_addi(2, 0, -3);
        prog[2] = i_r(6'h20, 3, 1, 2);
        prog[3] = i_r(6'h22, 4, 1, 2);
        prog[4] = i_r(6'h2A, 5, 2, 1);
        prog[5] = i_mem(6'h2B, 3, 80);
        prog[6] = i_mem(6'h2B, 4, 84);
        prog[7] = i_mem(6'h2B, 5, 88);
        prog[8] = HALT;
        load_prog(prog, 9);
        start_core();
        wait_done("alu_done");
        chk("alu_model20", mem_m[20], 32'd2);
        chk("alu_model21", mem_m[21], 32'd8);
        chk("alu_model22", mem_m[22], 32'd1);
        for (int w = 20; w <= 22; w++) host_read(w);
        chk("alu_lit22", Data_O, 32'd1);

        // Load and branch
        core_reset();
        mem_clear();
        host_write(16, 32'd7);
        host_write(17, 32'hFFFF);
        prog = new[5];
        prog[0] = i_mem(6'h23, 1, 64);
        prog[1] = i_beq(1, 1, 1);
        prog[2] = i_addi(2, 0, 9);
        prog[3] = i_mem(6'h2B, 2, 68);
        prog[4] = HALT;
        load_prog(prog, 5);
        start_core();
        wait_done("lb_done");
        chk("lb_model17", mem_m[17], 32'd0);
        host_read(17);
        chk("lb_lit17", Data_O, 32'd0);
        host_read(16);

        // Jump and R0
        core_reset();
        mem_clear();
        host_write(20, 32'h5555);
        host_write(21, 32'hAAAA);
        prog = new[7];
        prog[0] = i_addi(0, 0, 1);
        prog[1] = i_addi(1, 0, 5);
        prog[2] = i_mem(6'h2B, 0, 80);
        prog[3] = {6'h02, 26'd6};
        prog[4] = i_mem(6'h2B, 1, 84);
        prog[5] = 32'hFC00_0000 ^ 32'h0400_0000;
        prog[6] = HALT;
        load_prog(prog, 7);
        start_core();
        wait_done("jr0_done");
        host_read(20);
        chk("jr0_lit20", Data_O, 32'd0);
        host_read(21);
        chk("jr0_lit21", Data_O, 32'hAAAA);

        // Restart from S_DONE
        host_write(20, 32'h7777);
        start_core();
        wait_done("restart_done");
        host_read(20);
        chk("restart_lit20", Data_O, 32'd0);

        // Host writes while running are ignored; reset aborts a spinning program
        core_reset();
        mem_clear();
        prog = new[4];
        prog[0] = i_addi(1, 0, 1);
        prog[1] = i_beq(0, 0, -1);
        prog[2] = i_mem(6'h2B, 0, 12);
        prog[3] = 32'h1234_5678;
        load_prog(prog, 4);
        start_core();
        for (int i = 0; i < 10; i++) tick();
        host_write(3, 32'hDEAD);
        host_read(3);
        for (int i = 0; i < 5; i++) tick();
        chk("run_done_low", {31'b0, Done}, 32'd0);
        core_reset();
        host_read(3);
        chk("abort_lit3", Data_O, 32'h1234_5678);

        tick();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
